conv_frame_sequencer: RTL and testbench

Frame-level sequencer for the convolver datapath. It accepts one IMAGE_SIZE×IMAGE_SIZE frame of pixels over a valid/ready handshake and forwards each accepted pixel to the convolver line buffer as a registered shift strobe. It tracks row and column position, flags each pixel that completes a full KERNEL_SIZE×KERNEL_SIZE window, and delays that flag by the MAC pipeline depth so it aligns with the convolver result. It sits between the pixel source and the convolver, replacing free-running enable generation with handshake-driven sequencing.

---
 rtl/conv_frame_sequencer_if.sv | 84 ++++++++
 rtl/conv_frame_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer_if
//
// Bundles the pixel-source handshake, the convolver-side strobes and the frame
// status lines of conv_frame_sequencer into one interface.
//
// Parameters
//   DATA_WIDTH : pixel width
//   OW         : output coordinate width, max(1, $clog2(IMAGE_SIZE-KERNEL_SIZE+1))
//
// Signals
//   start       source -> seq   frame start pulse (sampled only when idle)
//   in_valid    source -> seq   pixel valid
//   in_data     source -> seq   pixel value
//   in_ready    seq -> source   sequencer can accept a pixel
//   shift_en    seq -> conv     registered load strobe for the line buffer
//   shift_data  seq -> conv     registered copy of the accepted pixel
//   conv_valid  seq -> conv     convolver result for (out_row, out_col) is valid
//   out_row     seq -> conv     output row index
//   out_col     seq -> conv     output column index
//   busy        seq -> source   high whenever the sequencer is not idle
//   done        seq -> source   one-cycle frame-complete pulse
//   stall_count seq -> source   STREAM cycles without in_valid (only with
//                               SEQ_STALL_COUNT_EN defined)
//
// Modports
//   master : pixel source / frame controller view
//   slave  : sequencer view
// -----------------------------------------------------------------------------
interface conv_frame_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int OW         = 5
);
   logic                  start;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  shift_en;
   logic [DATA_WIDTH-1:0] shift_data;
   logic                  conv_valid;
   logic [OW-1:0]         out_row;
   logic [OW-1:0]         out_col;
   logic                  busy;
   logic                  done;
`ifdef SEQ_STALL_COUNT_EN
   logic [15:0]           stall_count;
`endif

   modport master (
      output start,
      output in_valid,
      output in_data,
      input  in_ready,
      input  shift_en,
      input  shift_data,
      input  conv_valid,
      input  out_row,
      input  out_col,
      input  busy,
      input  done
`ifdef SEQ_STALL_COUNT_EN
      ,
      input  stall_count
`endif
   );

   modport slave (
      input  start,
      input  in_valid,
      input  in_data,
      output in_ready,
      output shift_en,
      output shift_data,
      output conv_valid,
      output out_row,
      output out_col,
      output busy,
      output done
`ifdef SEQ_STALL_COUNT_EN
      ,
      output stall_count
`endif
   );
endinterface

// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Frame-level sequencer for the convolver datapath. Accepts one
// IMAGE_SIZE x IMAGE_SIZE frame over a valid/ready handshake, forwards every
// accepted pixel to the convolver line buffer as a registered shift strobe,
// tracks raster position, and flags each pixel that completes a full
// KERNEL_SIZE x KERNEL_SIZE window. The window flag and its output
// coordinates are delayed by MAC_LATENCY so they line up with the MAC result.
//
// Parameters
//   KERNEL_SIZE : square kernel dimension (default 5)
//   IMAGE_SIZE  : square frame dimension, >= KERNEL_SIZE (default 28)
//   DATA_WIDTH  : pixel width (default 16)
//   MAC_LATENCY : cycles from shift_en to convolver result, >= 1 (default 2)
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : conv_frame_sequencer_if.slave (start, in_valid/in_data/in_ready,
//           shift_en/shift_data, conv_valid/out_row/out_col, busy, done and,
//           optionally, stall_count)
//
// Optional feature
//   SEQ_STALL_COUNT_EN : when defined, drives bus.stall_count, a saturating
//                        16-bit count of STREAM cycles with in_valid low,
//                        cleared on reset and on each accepted start.
//
// Frame timeline (last pixel accepted in cycle t, L = MAC_LATENCY):
//   t+1 .. t+1+L : DRAIN (delay line empties, last conv_valid at t+1+L)
//   t+2+L        : DONE, done = 1
//   t+3+L        : IDLE, busy = 0
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
   parameter int KERNEL_SIZE = 5,
   parameter int IMAGE_SIZE  = 28,
   parameter int DATA_WIDTH  = 16,
   parameter int MAC_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   conv_frame_sequencer_if.slave bus
);

   localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
   localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int RW       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int DCW      = $clog2(MAC_LATENCY + 1);

   localparam logic [RW-1:0]  POS_LAST   = RW'(IMAGE_SIZE - 1);
   localparam logic [RW-1:0]  WIN_FIRST  = RW'(KERNEL_SIZE - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MAC_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          state;
   logic            in_ready_r;
   logic            busy_r;
   logic            done_r;
   logic [RW-1:0]   row;
   logic [RW-1:0]   col;
   logic [DCW-1:0]  drain_cnt;

   logic            accept;
   logic            win_hit;

   // in_ready_r is high exactly while in STREAM, so it doubles as the
   // acceptance qualifier.
   assign accept  = bus.in_valid & in_ready_r;
   assign win_hit = accept && (row >= WIN_FIRST) && (col >= WIN_FIRST);

   // Control FSM: all handshake/status outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         row        <= '0;
         col        <= '0;
         drain_cnt  <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state      <= S_STREAM;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
                  row        <= '0;
                  col        <= '0;
               end
            end
            S_STREAM: begin
               if (accept) begin
                  if (col == POS_LAST) begin
                     col <= '0;
                     if (row == POS_LAST) begin
                        state      <= S_DRAIN;
                        in_ready_r <= 1'b0;
                        drain_cnt  <= '0;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // MAC_LATENCY+1 cycles: the last window flag leaves the delay
               // line on the final DRAIN cycle, one cycle ahead of done.
               if (drain_cnt == DRAIN_LAST) begin
                  state  <= S_DONE;
                  done_r <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               in_ready_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   // ---- stage p0: shift strobe, pixel copy and window flag ----
   logic                  shift_en_p0;
   logic [DATA_WIDTH-1:0] shift_data_p0;
   logic                  win_vld_p0;
   logic [OW-1:0]         win_row_p0;
   logic [OW-1:0]         win_col_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_en_p0   <= 1'b0;
         shift_data_p0 <= '0;
         win_vld_p0    <= 1'b0;
         win_row_p0    <= '0;
         win_col_p0    <= '0;
      end else begin
         shift_en_p0 <= accept;
         win_vld_p0  <= win_hit;
         if (accept) begin
            shift_data_p0 <= bus.in_data;
         end
         if (win_hit) begin
            win_row_p0 <= OW'(row - WIN_FIRST);
            win_col_p0 <= OW'(col - WIN_FIRST);
         end
      end
   end

   // ---- stages p1: MAC_LATENCY-deep delay line for window flag/coords ----
   // Coordinates only load alongside a valid flag, so the final stage holds
   // the last reported position while conv_valid is low.
   logic          dl_vld_p1 [MAC_LATENCY];
   logic [OW-1:0] dl_row_p1 [MAC_LATENCY];
   logic [OW-1:0] dl_col_p1 [MAC_LATENCY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MAC_LATENCY; k++) begin
            dl_vld_p1[k] <= 1'b0;
            dl_row_p1[k] <= '0;
            dl_col_p1[k] <= '0;
         end
      end else begin
         dl_vld_p1[0] <= win_vld_p0;
         if (win_vld_p0) begin
            dl_row_p1[0] <= win_row_p0;
            dl_col_p1[0] <= win_col_p0;
         end
         for (int k = 1; k < MAC_LATENCY; k++) begin
            dl_vld_p1[k] <= dl_vld_p1[k-1];
            if (dl_vld_p1[k-1]) begin
               dl_row_p1[k] <= dl_row_p1[k-1];
               dl_col_p1[k] <= dl_col_p1[k-1];
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.shift_en   = shift_en_p0;
   assign bus.shift_data = shift_data_p0;
   assign bus.conv_valid = dl_vld_p1[MAC_LATENCY-1];
   assign bus.out_row    = dl_row_p1[MAC_LATENCY-1];
   assign bus.out_col    = dl_col_p1[MAC_LATENCY-1];

`ifdef SEQ_STALL_COUNT_EN
   logic [15:0] stall_cnt;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         stall_cnt <= '0;
      end else if ((state == S_STREAM) && !bus.in_valid) begin
         stall_cnt <= sat_inc16(stall_cnt);
      end
   end

   assign bus.stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_frame_sequencer
//
// Randomized bench for conv_frame_sequencer. A reference model derives every
// expected output from the frame rules: pixel index -> (row, col) by division,
// window test on those coordinates, and event timestamps for shift strobes,
// conv_valid pulses and done. A second instance (IMAGE_SIZE = KERNEL_SIZE = 5)
// covers the single-window corner.
// -----------------------------------------------------------------------------
module tb_conv_frame_sequencer;

   localparam int IS = 28;
   localparam int K  = 5;
   localparam int ML = 2;
   localparam int DW = 16;
   localparam int NO = IS - K + 1;
   localparam int OW = (NO > 1) ? $clog2(NO) : 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_frame_sequencer_if #(.DATA_WIDTH(DW), .OW(OW)) bus ();
   conv_frame_sequencer_if #(.DATA_WIDTH(DW), .OW(1))  bus2 ();

   conv_frame_sequencer #(
      .KERNEL_SIZE(K), .IMAGE_SIZE(IS), .DATA_WIDTH(DW), .MAC_LATENCY(ML)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   conv_frame_sequencer #(
      .KERNEL_SIZE(5), .IMAGE_SIZE(5), .DATA_WIDTH(DW), .MAC_LATENCY(ML)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   typedef struct {
      longint t;
      int     r;
      int     c;
   } cv_ev_t;

   cv_ev_t  exp_q [$];
   longint  cyc = 0;
   bit      m_stream;
   longint  m_busy_end;
   longint  m_done_cyc;
   bit      m_shift_pend;
   longint  m_data;
   longint  m_or, m_oc;
   int      m_idx;

   // per-frame observations
   int      n_ready, n_shift, n_conv;
   longint  first_cv_cyc, acc_win0_cyc, last_acc_cyc, done_cyc_obs;
   longint  first_r, first_c, last_r, last_c;

   // small-frame instance observations
   int      acc2 = 0, n_cv2 = 0;
   longint  acc2_last_cyc = 0, cv2_cyc = 0, cv2_r = -1, cv2_c = -1, done2_cyc = 0;

   task automatic model_clear();
      exp_q.delete();
      m_stream     = 1'b0;
      m_busy_end   = 0;
      m_done_cyc   = -1;
      m_shift_pend = 1'b0;
      m_data       = 0;
      m_or         = 0;
      m_oc         = 0;
      m_idx        = 0;
   endtask

   initial begin
      model_clear();
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            model_clear();
         end else begin
            bit exp_busy, exp_cv;
            exp_busy = m_stream || (cyc < m_busy_end);
            exp_cv   = (exp_q.size() > 0) && (exp_q[0].t == cyc);
            chk("in_ready",   bus.in_ready,   m_stream);
            chk("busy",       bus.busy,       exp_busy);
            chk("done",       bus.done,       cyc == m_done_cyc);
            chk("shift_en",   bus.shift_en,   m_shift_pend);
            chk("shift_data", bus.shift_data, m_data);
            chk("conv_valid", bus.conv_valid, exp_cv);
            if (exp_cv) begin
               m_or = exp_q[0].r;
               m_oc = exp_q[0].c;
               void'(exp_q.pop_front());
            end
            chk("out_row", bus.out_row, m_or);
            chk("out_col", bus.out_col, m_oc);

            if (bus.in_ready) n_ready++;
            if (bus.shift_en) n_shift++;
            if (bus.conv_valid) begin
               n_conv++;
               if (n_conv == 1) begin
                  first_cv_cyc = cyc;
                  first_r = bus.out_row;
                  first_c = bus.out_col;
               end
               last_r = bus.out_row;
               last_c = bus.out_col;
            end
            if (bus.done) done_cyc_obs = cyc;

            m_shift_pend = 1'b0;
            if (!exp_busy && bus.start) begin
               m_stream = 1'b1;
               m_idx    = 0;
               n_ready = 0; n_shift = 0; n_conv = 0;
               first_cv_cyc = -1; acc_win0_cyc = -1; last_acc_cyc = -1; done_cyc_obs = -1;
               first_r = -1; first_c = -1; last_r = -1; last_c = -1;
            end else if (m_stream && bus.in_valid) begin
               int r, c;
               r = m_idx / IS;
               c = m_idx % IS;
               m_shift_pend = 1'b1;
               m_data       = bus.in_data;
               if (m_idx == (K-1)*IS + (K-1)) acc_win0_cyc = cyc;
               if (r >= K-1 && c >= K-1) exp_q.push_back('{cyc + 1 + ML, r - K + 1, c - K + 1});
               m_idx++;
               if (m_idx == IS*IS) begin
                  m_stream     = 1'b0;
                  m_done_cyc   = cyc + 2 + ML;
                  m_busy_end   = cyc + 3 + ML;
                  last_acc_cyc = cyc;
               end
            end
         end

         if (!reset) begin
            if (bus2.in_valid && bus2.in_ready) begin
               acc2++;
               if (acc2 == 25) acc2_last_cyc = cyc;
            end
            if (bus2.conv_valid) begin
               n_cv2++;
               cv2_cyc = cyc;
               cv2_r = bus2.out_row;
               cv2_c = bus2.out_col;
            end
            if (bus2.done) done2_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   // Entered just after a rising edge. Runs one frame; returns early (right
   // after the abort_at-th acceptance) when abort_at > 0.
   task automatic run_frame(input int pct, input int pre_gap, input bit noisy,
                            input int abort_at, input bit full_ready);
      int acc, guard;
      bit got;
      acc = 0; guard = 0; got = 1'b0;
      bus.in_valid = 1'b0;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (pre_gap) @(posedge clk);
      #1;
      while (acc < IS*IS && guard < 5000) begin
         bus.in_valid = (($urandom % 100) < pct);
         bus.in_data  = DW'($urandom);
         bus.start    = noisy && (($urandom % 8) == 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc++;
         if (abort_at > 0 && acc == abort_at) return;
         @(posedge clk); #1;
         guard++;
      end
      if (acc != IS*IS) chk("frame_accepts", acc, IS*IS);
      bus.in_valid = 1'b0;
      bus.start    = noisy;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
`ifdef SEQ_STALL_COUNT_EN
            if (pre_gap > 0) chk("stall_count", bus.stall_count, pre_gap);
`endif
         end
      end
      chk("done_seen", got, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("n_shift",      n_shift, IS*IS);
      chk("n_conv",       n_conv, NO*NO);
      chk("first_cv_lat", first_cv_cyc - acc_win0_cyc, ML + 1);
      chk("first_row",    first_r, 0);
      chk("first_col",    first_c, 0);
      chk("last_row",     last_r, NO - 1);
      chk("last_col",     last_c, NO - 1);
      chk("done_lat",     done_cyc_obs - last_acc_cyc, ML + 2);
      chk("pending_cv",   exp_q.size(), 0);
      if (full_ready) chk("n_ready", n_ready, IS*IS);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;
      bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",   bus.in_ready, 0);
      chk("rst_shift_en",   bus.shift_en, 0);
      chk("rst_conv_valid", bus.conv_valid, 0);
      chk("rst_busy",       bus.busy, 0);
      chk("rst_done",       bus.done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // full frame, in_valid held high
      run_frame(100, 0, 1'b0, 0, 1'b1);
      // random 50% gaps, stray starts during STREAM and DRAIN
      run_frame(50, 0, 1'b1, 0, 1'b0);

      // asynchronous reset after 300 pixels
      run_frame(100, 0, 1'b0, 300, 1'b0);
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("arst_in_ready",   bus.in_ready, 0);
      chk("arst_shift_en",   bus.shift_en, 0);
      chk("arst_shift_data", bus.shift_data, 0);
      chk("arst_conv_valid", bus.conv_valid, 0);
      chk("arst_out_row",    bus.out_row, 0);
      chk("arst_out_col",    bus.out_col, 0);
      chk("arst_busy",       bus.busy, 0);
      chk("arst_done",       bus.done, 0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      // pixels offered without a start must be ignored
      bus.in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      run_frame(100, 0, 1'b0, 0, 1'b1);

      // single-window frame on the 5x5 instance
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start    = 1'b0;
      bus2.in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus2.in_data = DW'($urandom);
         @(posedge clk); #1;
      end
      bus2.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("s5_accepts", acc2, 25);
      chk("s5_n_conv",  n_cv2, 1);
      chk("s5_cv_lat",  cv2_cyc - acc2_last_cyc, ML + 1);
      chk("s5_row",     cv2_r, 0);
      chk("s5_col",     cv2_c, 0);
      chk("s5_done_lat", done2_cyc - acc2_last_cyc, ML + 2);

`ifdef SEQ_STALL_COUNT_EN
      run_frame(100, 10, 1'b0, 0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
